// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480 timing, line/frame totals,
// the 6-bit {r,g,b} colour type and packing onto the 8-bit VGA PMOD.
package vga_pkg;

    localparam int H_PIXELS_DEF      = 640;
    localparam int H_FRONT_PORCH_DEF = 16;
    localparam int H_SYNC_PULSE_DEF  = 96;
    localparam int H_BACK_PORCH_DEF  = 48;
    localparam int V_PIXELS_DEF      = 480;
    localparam int V_FRONT_PORCH_DEF = 10;
    localparam int V_SYNC_PULSE_DEF  = 2;
    localparam int V_BACK_PORCH_DEF  = 33;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } colour_t;

    // Syncs and flags that travel alongside a pixel through the render pipeline.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic hit;
    } pipe_t;

    localparam pipe_t      PIPE_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, hit: 1'b0};
    localparam logic [7:0] PMOD_IDLE = 8'b1000_1000;

    function automatic int h_total(input int pixels, input int front, input int sync, input int back);
        return pixels + front + sync + back;
    endfunction

    function automatic int v_total(input int pixels, input int front, input int sync, input int back);
        return pixels + front + sync + back;
    endfunction

    function automatic colour_t palette_lookup(input logic [23:0] palette, input logic [1:0] idx);
        colour_t c;
        case (idx)
            2'd0:    c = palette[5:0];
            2'd1:    c = palette[11:6];
            2'd2:    c = palette[17:12];
            default: c = palette[23:18];
        endcase
        return c;
    endfunction

    function automatic logic [7:0] pmod_pack(input logic hsync, input logic vsync, input colour_t c);
        return {hsync, c.b[0], c.g[0], c.r[0], vsync, c.b[1], c.g[1], c.r[1]};
    endfunction

endpackage

// File: rtl/sprite_vga_if.sv
// Sprite ROM port: address out from the renderer, 2-bit palette index back one clock later.
interface sprite_vga_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] sprite_addr;
    logic [1:0]        sprite_data;

    modport master (output sprite_addr, input sprite_data);
    modport slave  (input sprite_addr, output sprite_data);
endinterface

// File: rtl/vga_timing.sv
// Pixel/line counters with active-low syncs, display enable and the frame wrap pulses.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_PIXELS      = H_PIXELS_DEF,
    parameter int H_FRONT_PORCH = H_FRONT_PORCH_DEF,
    parameter int H_SYNC_PULSE  = H_SYNC_PULSE_DEF,
    parameter int H_BACK_PORCH  = H_BACK_PORCH_DEF,
    parameter int V_PIXELS      = V_PIXELS_DEF,
    parameter int V_FRONT_PORCH = V_FRONT_PORCH_DEF,
    parameter int V_SYNC_PULSE  = V_SYNC_PULSE_DEF,
    parameter int V_BACK_PORCH  = V_BACK_PORCH_DEF,
    parameter int X_W = $clog2(h_total(H_PIXELS, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH)),
    parameter int Y_W = $clog2(v_total(V_PIXELS, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH))
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic [X_W-1:0] pixel_x,
    output logic [Y_W-1:0] pixel_y,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic           frame_end,
    output logic           frame_start
);

    localparam int H_TOTAL = h_total(H_PIXELS, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH);
    localparam int V_TOTAL = v_total(V_PIXELS, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH);

    localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] X_VIS    = X_W'(H_PIXELS);
    localparam logic [X_W-1:0] HS_START = X_W'(H_PIXELS + H_FRONT_PORCH);
    localparam logic [X_W-1:0] HS_END   = X_W'(H_PIXELS + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_VIS    = Y_W'(V_PIXELS);
    localparam logic [Y_W-1:0] VS_START = Y_W'(V_PIXELS + V_FRONT_PORCH);
    localparam logic [Y_W-1:0] VS_END   = Y_W'(V_PIXELS + V_FRONT_PORCH + V_SYNC_PULSE);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           fs_q, fs_d;

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        x_d  = x_q + 1'b1;
        y_d  = y_q;
        fs_d = 1'b0;
        if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
                y_d  = '0;
                fs_d = 1'b1;
            end else begin
                y_d = y_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            y_q  <= '0;
            fs_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            fs_q <= fs_d;
        end
    end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign hsync       = ~((x_q >= HS_START) && (x_q < HS_END));
    assign vsync       = ~((y_q >= VS_START) && (y_q < VS_END));
    assign de          = (x_q < X_VIS) && (y_q < Y_VIS);
    assign frame_end   = fs_d;
    assign frame_start = fs_q;

endmodule

// File: rtl/sprite_vga.sv
// VGA engine: timing plus a 3-stage sprite render pipeline over a solid background.
// Define SPRITE_VGA_BOUNCE_EN to make the sprite move and bounce; otherwise it sits at (0,0).
module sprite_vga
    import vga_pkg::*;
#(
    parameter int          H_PIXELS      = H_PIXELS_DEF,
    parameter int          H_FRONT_PORCH = H_FRONT_PORCH_DEF,
    parameter int          H_SYNC_PULSE  = H_SYNC_PULSE_DEF,
    parameter int          H_BACK_PORCH  = H_BACK_PORCH_DEF,
    parameter int          V_PIXELS      = V_PIXELS_DEF,
    parameter int          V_FRONT_PORCH = V_FRONT_PORCH_DEF,
    parameter int          V_SYNC_PULSE  = V_SYNC_PULSE_DEF,
    parameter int          V_BACK_PORCH  = V_BACK_PORCH_DEF,
    parameter int          SPRITE_W      = 32,
    parameter int          SPRITE_H      = 32,
    parameter int          SCALE_BITS    = 2,
    parameter int          NUM_FRAMES    = 4,
    parameter int          FRAME_HOLD    = 8,
    parameter int          STEP_X        = 2,
    parameter int          STEP_Y        = 1,
    parameter logic [23:0] PALETTE       = 24'h00_3F_30_0C,
    parameter logic [5:0]  BG_COLOUR     = 6'b000111
) (
    input  logic               clk,
    input  logic               rst_n,
    sprite_vga_if.master       rom,
    output logic               frame_start,
    output logic [7:0]         vga_pmod
);

    localparam int H_TOTAL  = h_total(H_PIXELS, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH);
    localparam int V_TOTAL  = v_total(V_PIXELS, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH);
    localparam int X_W      = $clog2(H_TOTAL);
    localparam int Y_W      = $clog2(V_TOTAL);
    localparam int COL_W    = $clog2(SPRITE_W);
    localparam int ROW_W    = $clog2(SPRITE_H);
    localparam int FRM_W    = $clog2(NUM_FRAMES);
    localparam int ADDR_W   = FRM_W + ROW_W + COL_W;
    localparam int HOLD_W   = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int SPR_W_PX = SPRITE_W << SCALE_BITS;
    localparam int SPR_H_PX = SPRITE_H << SCALE_BITS;
    localparam int X_MAX    = H_PIXELS - SPR_W_PX;
    localparam int Y_MAX    = V_PIXELS - SPR_H_PX;

    localparam logic [X_W:0]        HIT_W     = (X_W + 1)'(SPR_W_PX);
    localparam logic [Y_W:0]        HIT_H     = (Y_W + 1)'(SPR_H_PX);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(FRAME_HOLD - 1);

    if (X_MAX < STEP_X || Y_MAX < STEP_Y) begin : g_geometry_check
        $error("sprite_vga: scaled sprite plus one step does not fit the visible area");
    end

    logic [X_W-1:0] pixel_x;
    logic [Y_W-1:0] pixel_y;
    logic           hsync, vsync, de, frame_end;

    vga_timing #(
        .H_PIXELS      (H_PIXELS),
        .H_FRONT_PORCH (H_FRONT_PORCH),
        .H_SYNC_PULSE  (H_SYNC_PULSE),
        .H_BACK_PORCH  (H_BACK_PORCH),
        .V_PIXELS      (V_PIXELS),
        .V_FRONT_PORCH (V_FRONT_PORCH),
        .V_SYNC_PULSE  (V_SYNC_PULSE),
        .V_BACK_PORCH  (V_BACK_PORCH),
        .X_W           (X_W),
        .Y_W           (Y_W)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_end   (frame_end),
        .frame_start (frame_start)
    );

    logic [X_W-1:0] sx;
    logic [Y_W-1:0] sy;

`ifdef SPRITE_VGA_BOUNCE_EN
    localparam logic [X_W:0]   X_MAX_E  = (X_W + 1)'(X_MAX);
    localparam logic [X_W:0]   STEP_X_E = (X_W + 1)'(STEP_X);
    localparam logic [X_W-1:0] X_MAX_N  = X_W'(X_MAX);
    localparam logic [Y_W:0]   Y_MAX_E  = (Y_W + 1)'(Y_MAX);
    localparam logic [Y_W:0]   STEP_Y_E = (Y_W + 1)'(STEP_Y);
    localparam logic [Y_W-1:0] Y_MAX_N  = Y_W'(Y_MAX);

    logic [X_W-1:0] sx_q, sx_d;
    logic [Y_W-1:0] sy_q, sy_d;
    logic           dir_x_q, dir_x_d, dir_y_q, dir_y_d;  // 0 = increasing

    // Position moves on the wrap edge, so the new value is in place from pixel (0,0) onward.
    always_comb begin
        sx_d    = sx_q;
        sy_d    = sy_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (frame_end) begin
            if (!dir_x_q) begin
                if ({1'b0, sx_q} + STEP_X_E >= X_MAX_E) begin
                    sx_d    = X_MAX_N;
                    dir_x_d = 1'b1;
                end else begin
                    sx_d = sx_q + STEP_X_E[X_W-1:0];
                end
            end else if ({1'b0, sx_q} <= STEP_X_E) begin
                sx_d    = '0;
                dir_x_d = 1'b0;
            end else begin
                sx_d = sx_q - STEP_X_E[X_W-1:0];
            end

            if (!dir_y_q) begin
                if ({1'b0, sy_q} + STEP_Y_E >= Y_MAX_E) begin
                    sy_d    = Y_MAX_N;
                    dir_y_d = 1'b1;
                end else begin
                    sy_d = sy_q + STEP_Y_E[Y_W-1:0];
                end
            end else if ({1'b0, sy_q} <= STEP_Y_E) begin
                sy_d    = '0;
                dir_y_d = 1'b0;
            end else begin
                sy_d = sy_q - STEP_Y_E[Y_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_q    <= '0;
            sy_q    <= '0;
            dir_x_q <= 1'b0;
            dir_y_q <= 1'b0;
        end else begin
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
        end
    end

    assign sx = sx_q;
    assign sy = sy_q;
`else
    assign sx = '0;
    assign sy = '0;
`endif

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [FRM_W-1:0]  anim_q, anim_d;

    always_comb begin
        hold_d = hold_q;
        anim_d = anim_q;
        if (frame_end) begin
            if (hold_q == HOLD_LAST) begin
                hold_d = '0;
                anim_d = anim_q + 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    // Stage 1: hit test and ROM address; the difference is one bit wider so "left of sprite" wraps large.
    logic [X_W:0]        dx;
    logic [Y_W:0]        dy;
    pipe_t               s1_d, s1_q, s2_q;
    logic [ADDR_W-1:0]   addr_d, addr_q;

    always_comb begin
        dx       = {1'b0, pixel_x} - {1'b0, sx};
        dy       = {1'b0, pixel_y} - {1'b0, sy};
        s1_d.hsync = hsync;
        s1_d.vsync = vsync;
        s1_d.de    = de;
        s1_d.hit   = (dx < HIT_W) && (dy < HIT_H);
        addr_d   = {anim_q, dy[SCALE_BITS +: ROW_W], dx[SCALE_BITS +: COL_W]};
    end

    // Stage 3 input: ROM index is valid while stage 2 holds the same pixel.
    colour_t    colour;
    logic [7:0] pmod_d, pmod_q;

    always_comb begin
        colour = '0;
        if (s2_q.de) begin
            colour = BG_COLOUR;
            if (s2_q.hit && rom.sprite_data != 2'd0) begin
                colour = palette_lookup(PALETTE, rom.sprite_data);
            end
        end
        pmod_d = pmod_pack(s2_q.hsync, s2_q.vsync, colour);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            anim_q <= '0;
            s1_q   <= PIPE_IDLE;
            s2_q   <= PIPE_IDLE;
            addr_q <= '0;
            pmod_q <= PMOD_IDLE;
        end else begin
            hold_q <= hold_d;
            anim_q <= anim_d;
            s1_q   <= s1_d;
            s2_q   <= s1_q;
            addr_q <= addr_d;
            pmod_q <= pmod_d;
        end
    end

    assign rom.sprite_addr = addr_q;
    assign vga_pmod        = pmod_q;

endmodule

// File: tb/tb_sprite_vga.sv
// Bench for sprite_vga: a shrunken-geometry instance checked cycle by cycle against a
// frame-level model with random ROM contents, plus spot checks on a default 640x480 instance.
module tb_sprite_vga;

    // Shrunken geometry: 48x25 total, 40x20 visible, 4x4 sprite scaled x2.
    localparam int HP = 40, HFP = 2, HSW = 4, HBP = 2;
    localparam int VP = 20, VFP = 1, VSW = 2, VBP = 2;
    localparam int HT = HP + HFP + HSW + HBP;
    localparam int VT = VP + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int SW = 4, SH = 4, SB = 1, SCALE = 2, NF = 4, HOLD = 3, STX = 3, STY = 2;
    localparam logic [23:0] PAL = 24'h9E_5B_2C;
    localparam logic [5:0]  BG  = 6'b011010;
    localparam int X_MAX = HP - SW * SCALE;
    localparam int Y_MAX = VP - SH * SCALE;
    localparam int S_AW = 6;
    localparam int D_AW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sprite_vga_if #(.ADDR_W(S_AW)) s_bus ();
    sprite_vga_if #(.ADDR_W(D_AW)) d_bus ();

    logic       s_fs, d_fs;
    logic [7:0] s_pmod, d_pmod;

    sprite_vga #(
        .H_PIXELS (HP), .H_FRONT_PORCH (HFP), .H_SYNC_PULSE (HSW), .H_BACK_PORCH (HBP),
        .V_PIXELS (VP), .V_FRONT_PORCH (VFP), .V_SYNC_PULSE (VSW), .V_BACK_PORCH (VBP),
        .SPRITE_W (SW), .SPRITE_H (SH), .SCALE_BITS (SB), .NUM_FRAMES (NF),
        .FRAME_HOLD (HOLD), .STEP_X (STX), .STEP_Y (STY),
        .PALETTE (PAL), .BG_COLOUR (BG)
    ) u_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom         (s_bus),
        .frame_start (s_fs),
        .vga_pmod    (s_pmod)
    );

    sprite_vga u_full (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom         (d_bus),
        .frame_start (d_fs),
        .vga_pmod    (d_pmod)
    );

    logic [1:0] s_rom [SW*SH*NF];
    logic [1:0] d_rom [1 << D_AW];

    always @(posedge clk) begin
        s_bus.sprite_data <= s_rom[s_bus.sprite_addr];
        d_bus.sprite_data <= d_rom[d_bus.sprite_addr];
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          mx [64];
    int          my [64];
    logic [23:0] pal_v = PAL;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // c = {r[1:0], g[1:0], b[1:0]}; PMOD = {hs, b0, g0, r0, vs, b1, g1, r1}
    function automatic logic [7:0] pack(input logic h, input logic v, input logic [5:0] c);
        return {h, c[0], c[2], c[4], v, c[1], c[3], c[5]};
    endfunction

    // Sprite position for each frame after reset, stepped with the bounce rules.
    task automatic build_motion();
        int x = 0, y = 0;
        bit xneg = 0, yneg = 0;
        for (int f = 0; f < 64; f++) begin
            mx[f] = x;
            my[f] = y;
`ifdef SPRITE_VGA_BOUNCE_EN
            if (!xneg) begin
                if (x + STX >= X_MAX) begin x = X_MAX; xneg = 1; end else x = x + STX;
            end else begin
                if (x - STX <= 0) begin x = 0; xneg = 0; end else x = x - STX;
            end
            if (!yneg) begin
                if (y + STY >= Y_MAX) begin y = Y_MAX; yneg = 1; end else y = y + STY;
            end else begin
                if (y - STY <= 0) begin y = 0; yneg = 0; end else y = y - STY;
            end
`endif
        end
    endtask

    function automatic void locate(input int n, output int f, output int x, output int y);
        f = n / FRAME;
        x = (n % FRAME) % HT;
        y = (n % FRAME) / HT;
    endfunction

    function automatic bit in_sprite(input int f, input int x, input int y);
        return x >= mx[f] && x < mx[f] + SW * SCALE && y >= my[f] && y < my[f] + SH * SCALE;
    endfunction

    function automatic int rom_index(input int f, input int x, input int y);
        return ((f / HOLD) % NF) * SW * SH + ((y - my[f]) / SCALE) * SW + (x - mx[f]) / SCALE;
    endfunction

    function automatic logic [7:0] exp_pmod(input int k);
        int f, x, y, idx;
        logic h, v;
        logic [5:0] c;
        if (k < 3) return 8'h88;
        locate(k - 3, f, x, y);
        h = !(x >= HP + HFP && x < HP + HFP + HSW);
        v = !(y >= VP + VFP && y < VP + VFP + VSW);
        c = 6'd0;
        if (x < HP && y < VP) begin
            c = BG;
            if (in_sprite(f, x, y)) begin
                idx = rom_index(f, x, y);
                if (s_rom[idx] != 2'd0) c = pal_v[6 * s_rom[idx] +: 6];
            end
        end
        return pack(h, v, c);
    endfunction

    // Spot checks on the default-geometry instance, k clocks after reset release.
    task automatic full_checks(input int k);
        case (k)
            3:    check("full bg at (0,0)", d_pmod, pack(1'b1, 1'b1, 6'b000111));
            658:  check("full hsync high before pulse", d_pmod[7], 1'b1);
            659:  check("full hsync fall", d_pmod[7], 1'b0);
            754:  check("full hsync low at pulse end", d_pmod[7], 1'b0);
            755:  check("full hsync rise", d_pmod[7], 1'b1);
            800:  check("full no frame_start on line wrap", d_fs, 1'b0);
            1459: check("full hsync fall line 1", d_pmod[7], 1'b0);
            2415: check("full (12,3) transparent", d_pmod, pack(1'b1, 1'b1, 6'b000111));
            3213: check("full addr for (12,4)", d_bus.sprite_addr, 12'd35);
            3214: check("full (11,4) transparent", d_pmod, pack(1'b1, 1'b1, 6'b000111));
            3215: check("full (12,4) palette 2", d_pmod, pack(1'b1, 1'b1, 6'b110011));
            3219: check("full (16,4) transparent", d_pmod, pack(1'b1, 1'b1, 6'b000111));
            3903: check("full (700,4) blank in hsync", d_pmod, pack(1'b0, 1'b1, 6'b000000));
            default: ;
        endcase
    endtask

    task automatic run(input int n_cycles, input bit with_full);
        int f, x, y;
        for (int k = 1; k <= n_cycles; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vga k=%0d", k), s_pmod, exp_pmod(k));
            check($sformatf("frame_start k=%0d", k), s_fs, (k % FRAME) == 0);
            locate(k - 1, f, x, y);
            if (in_sprite(f, x, y))
                check($sformatf("addr k=%0d", k), s_bus.sprite_addr, rom_index(f, x, y));
            if (with_full) full_checks(k);
        end
    endtask

    initial begin
        for (int i = 0; i < SW * SH * NF; i++) s_rom[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < (1 << D_AW); i++) d_rom[i] = 2'd0;
        d_rom[35] = 2'd2;
        build_motion();

        repeat (4) @(negedge clk);
        check("reset vga", s_pmod, 8'h88);
        check("reset addr", s_bus.sprite_addr, 0);
        check("reset frame_start", s_fs, 1'b0);
        check("full reset vga", d_pmod, 8'h88);
        check("full reset addr", d_bus.sprite_addr, 0);
        rst_n = 1'b1;

        run(14 * FRAME + 537, 1'b1);

        rst_n = 1'b0;
        #1;
        check("mid reset vga", s_pmod, 8'h88);
        check("mid reset addr", s_bus.sprite_addr, 0);
        check("mid reset frame_start", s_fs, 1'b0);
        for (int i = 0; i < SW * SH * NF; i++) s_rom[i] = 2'($urandom_range(0, 3));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run(16 * FRAME + 10, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sprite_vga.md
Name: sprite_vga

Overview:
- Next-generation VGA pixel engine driving the 8-bit VGA PMOD from one clock.
- Generates 640x480-class timing and renders one scaled, animated, multi-frame sprite over a solid background.
- Sprite bitmap lives in an external 1-cycle-latency ROM addressed by this block; 2-bit palette indices are mapped through a parameter palette.
- Sprite moves across the screen and bounces off the edges, which the first-generation renderer could not do.

Parameters:
- H_PIXELS, 640, visible columns
- H_FRONT_PORCH / H_SYNC_PULSE / H_BACK_PORCH, 16 / 96 / 48, horizontal timing
- V_PIXELS, 480, visible lines
- V_FRONT_PORCH / V_SYNC_PULSE / V_BACK_PORCH, 10 / 2 / 33, vertical timing
- SPRITE_W, 32, bitmap width in source pixels (power of 2)
- SPRITE_H, 32, bitmap height in source pixels (power of 2)
- SCALE_BITS, 2, on-screen scale = 2**SCALE_BITS
- NUM_FRAMES, 4, animation frames in ROM (power of 2)
- FRAME_HOLD, 8, video frames per animation frame (>=1)
- STEP_X / STEP_Y, 2 / 1, screen pixels moved per video frame
- PALETTE, 24'h00_3F_30_0C, four 6-bit {r,g,b} entries, index 0 in bits 5:0
- BG_COLOUR, 6'b000111, background {r,g,b}

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- sprite_addr  out  log2(NUM_FRAMES*SPRITE_W*SPRITE_H)  ROM address {frame, row, col}
- sprite_data  in  2  palette index, valid one clk after sprite_addr
- frame_start  out  1  one-cycle pulse when counters wrap to (0,0)
- vga_pmod  out  8  {hsync, b[0], g[0], r[0], vsync, b[1], g[1], r[1]}

Behaviour:
- Reset: counters, sprite position, direction flags (+x,+y), animation frame and hold counter all 0; sprite_addr 0; frame_start 0; vga_pmod = 8'b1000_1000 (syncs high, colour 0).
- Counters: pixel_x wraps at H_TOTAL-1, pixel_y increments on that wrap and wraps at V_TOTAL-1. hsync is low for pixel_x in [H_PIXELS+H_FRONT_PORCH, +H_SYNC_PULSE); vsync is derived the same way from pixel_y. Both are active-low.
- Pipeline, stage n = counter value:
  - n+1: registers sprite hit flag, sprite_addr and delayed syncs/display-enable.
  - n+2: sprite_data is valid.
  - n+3: vga_pmod is registered.
  - Total latency is 3 clocks for sync and colour alike. No bubbles.
- Hit: pixel_x-sx in [0, SPRITE_W<<SCALE_BITS) and pixel_y-sy in [0, SPRITE_H<<SCALE_BITS), computed unsigned on widths one bit wider than the counters. Column/row = difference >> SCALE_BITS.
- Colour:
  - Outside the visible area: 0.
  - Visible and hit with index != 0: PALETTE[index].
  - Otherwise: BG_COLOUR. Index 0 is transparent.
- Motion: updated only on the frame_start cycle, so the position is stable for a whole frame.
  - X_MAX = H_PIXELS - (SPRITE_W<<SCALE_BITS).
  - If dir_x=+ and sx+STEP_X >= X_MAX: sx = X_MAX, dir_x flips. The mirrored rule at 0 clamps to 0.
  - Y axis is identical with Y_MAX. Simultaneous X and Y bounce (corner) flips both.
- Animation: hold counter counts frame_starts. At FRAME_HOLD-1 it clears and anim_frame increments, wrapping NUM_FRAMES-1 to 0.
- Reset mid-frame: immediate return to reset state. The first frame after reset is complete and correct.

Optional Feature:
- Macro SPRITE_VGA_BOUNCE_EN.
- Defined: motion as above.
- Undefined: sprite fixed at (0,0), direction registers and motion logic absent; animation still runs.

Decomposition:
- Package vga_pkg: default timing localparams, H_TOTAL/V_TOTAL functions, colour typedef (6-bit {r,g,b}), PMOD packing function.
- Natural sub-module vga_timing: counters, syncs, display-enable, frame_start. sprite_vga instantiates it and adds the sprite pipeline.

Test Plan:
- Reset: hold rst_n=0 -> vga_pmod 8'h88, sprite_addr 0. Release -> hsync falls 3+656 clks later, low for 96 clks. Line length 800, frame 800*525 clks, one frame_start per frame.
- Address: ROM model returns index 2 at address {0,row 1,col 3} -> pixel (12,4) of frame 0 shows PALETTE[2] at vga_pmod 3 clks after the counter reaches it. Neighbouring index-0 pixels show BG_COLOUR.
- Blanking: sprite overlapping with pixel_x >= 640 -> colour bits 0, syncs unaffected.
- Bounce: force sx = X_MAX-1 (=511), dir +, STEP_X 2 -> next frame sx = 512 and dir flips; the following frame sx = 510.
- Animation: FRAME_HOLD 8, NUM_FRAMES 4 -> frame field of sprite_addr steps 0,1,2,3,0 every 8 frame_starts.
- Macro off: 200 frames -> sprite always at (0,0); palette pixels still correct.
